// File: rtl/pc_ras_unit_if.sv
// pc_ras_unit_if: control/fetch-side bundle for the program-counter unit.
//   PC_OP       operation select from the control unit
//   FROM_IMMED  jump/call target
//   PC_COUNT    current program counter
//   SP_COUNT    number of valid return-address-stack entries
//   TOS         top-of-stack entry (zero when empty)
//   STACK_EMPTY / STACK_FULL / STACK_ERR  stack status flags
// master = control side, slave = pc_ras_unit.
interface pc_ras_unit_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned SP_W = $clog2(DEPTH + 1);

  logic [2:0]        PC_OP;
  logic [ADDR_W-1:0] FROM_IMMED;
  logic [ADDR_W-1:0] PC_COUNT;
  logic [SP_W-1:0]   SP_COUNT;
  logic [ADDR_W-1:0] TOS;
  logic              STACK_EMPTY;
  logic              STACK_FULL;
  logic              STACK_ERR;

  modport master (
    output PC_OP, FROM_IMMED,
    input  PC_COUNT, SP_COUNT, TOS, STACK_EMPTY, STACK_FULL, STACK_ERR
  );

  modport slave (
    input  PC_OP, FROM_IMMED,
    output PC_COUNT, SP_COUNT, TOS, STACK_EMPTY, STACK_FULL, STACK_ERR
  );
endinterface

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: RAT CPU program counter with an internal return-address stack.
//   CLK  system clock, rising edge
//   RST  synchronous active-high reset (overrides any PC_OP)
//   bus  pc_ras_unit_if slave: PC_OP/FROM_IMMED in; PC_COUNT, SP_COUNT, TOS,
//        STACK_EMPTY, STACK_FULL, sticky STACK_ERR out
// CALL/INTR push a return address, RET/RETI pop it into the PC. A push when
// full or a pop when empty is dropped entirely and sets STACK_ERR.
module pc_ras_unit #(
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DEPTH     = 8,
  parameter logic [ADDR_W-1:0] INTR_VEC  = ADDR_W'('h3FF),
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic         CLK,
  input  logic         RST,
  pc_ras_unit_if.slave bus
);
  localparam int unsigned SP_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_INC  = 3'b001,
    OP_JUMP = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100,
    OP_INTR = 3'b101,
    OP_RETI = 3'b110,
    OP_RSVD = 3'b111
  } pc_op_e;

  pc_op_e            op;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
  logic [SP_W-1:0]   sp, sp_nxt, sp_dec;
  logic              err, err_nxt;
  logic              push;
  logic [ADDR_W-1:0] push_val;
  logic              empty, full;
  logic [ADDR_W-1:0] tos;
  logic [ADDR_W-1:0] stack [DEPTH];

  assign op     = pc_op_e'(bus.PC_OP);
  assign pc_inc = pc + ADDR_W'(1);
  assign sp_dec = sp - SP_W'(1);
  assign empty  = (sp == '0);
  assign full   = (sp == SP_W'(DEPTH));
  assign tos    = empty ? '0 : stack[sp_dec[IDX_W-1:0]];

  always_comb begin
    pc_nxt   = pc;
    sp_nxt   = sp;
    err_nxt  = err;
    push     = 1'b0;
    push_val = pc_inc;
    case (op)
      OP_INC:  pc_nxt = pc_inc;
      OP_JUMP: pc_nxt = bus.FROM_IMMED;
      OP_CALL, OP_INTR: begin
        if (full) begin
          err_nxt = 1'b1;
        end else begin
          push     = 1'b1;
          push_val = (op == OP_CALL) ? pc_inc : pc;
          pc_nxt   = (op == OP_CALL) ? bus.FROM_IMMED : INTR_VEC;
          sp_nxt   = sp + SP_W'(1);
        end
      end
      OP_RET, OP_RETI: begin
        if (empty) begin
          err_nxt = 1'b1;
        end else begin
          pc_nxt = tos;
          sp_nxt = sp_dec;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc  <= RESET_VEC;
      sp  <= '0;
      err <= 1'b0;
    end else begin
      pc  <= pc_nxt;
      sp  <= sp_nxt;
      err <= err_nxt;
    end
  end

  // Stack contents need no reset; only entries below SP are ever read.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      stack[sp[IDX_W-1:0]] <= push_val;
    end
  end

  assign bus.PC_COUNT    = pc;
  assign bus.SP_COUNT    = sp;
  assign bus.TOS         = tos;
  assign bus.STACK_EMPTY = empty;
  assign bus.STACK_FULL  = full;
  assign bus.STACK_ERR   = err;
endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised program-counter unit for the RAT CPU.
- Combines the PC register, the next-PC source selection and an internal hardware return-address stack (RAS).
- Replaces the external FROM_STACK path: CALL, RET and interrupt entry push and pop return addresses internally.
- Sits between the control unit (supplies PC_OP) and the instruction memory (consumes PC_COUNT).

Parameters:
ADDR_W, 10, width of PC and all stored addresses
DEPTH, 8, number of RAS entries (>=1)
INTR_VEC, 'h3FF, PC value loaded on interrupt entry
RESET_VEC, 'h000, PC value loaded on reset

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
PC_OP  input  3  operation select (encoding below)
FROM_IMMED  input  ADDR_W  jump/call target from instruction
PC_COUNT  output  ADDR_W  current program counter (registered)
SP_COUNT  output  $clog2(DEPTH+1)  number of valid RAS entries (registered)
TOS  output  ADDR_W  top-of-stack entry; all zeros when empty (combinational from registered state)
STACK_EMPTY  output  1  SP_COUNT==0
STACK_FULL  output  1  SP_COUNT==DEPTH
STACK_ERR  output  1  sticky overflow/underflow flag (registered)

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high. All outputs are registered or derived from registered state. No combinational input-to-output paths.
- Reset, sampled on the CLK edge and overriding every PC_OP:
  - PC_COUNT=RESET_VEC, SP_COUNT=0, STACK_ERR=0.
  - RAS contents are don't-care; TOS reads 0.
- PC_OP encoding; each op takes effect at the next rising edge (1-cycle latency):
  - 000 HOLD: no state change.
  - 001 INC: PC<=PC+1, modulo 2^ADDR_W ('h3FF -> 'h000 at default width).
  - 010 JUMP: PC<=FROM_IMMED.
  - 011 CALL: push PC+1 (wrapped); PC<=FROM_IMMED; SP+1.
  - 100 RET: PC<=TOS; SP-1.
  - 101 INTR: push current PC (not PC+1); PC<=INTR_VEC; SP+1.
  - 110 RETI: identical to RET.
  - 111 reserved: behaves as HOLD.
- Overflow: CALL or INTR while STACK_FULL.
  - The whole operation is suppressed: PC, SP and stack contents are unchanged.
  - STACK_ERR<=1.
- Underflow: RET or RETI while STACK_EMPTY.
  - The whole operation is suppressed.
  - STACK_ERR<=1.
- STACK_ERR stays set until RST. It has no other clear path.
- Stack is LIFO, with a single push or pop per cycle at most.
  - Entry index SP_COUNT-1 is TOS.
  - Entries below TOS are never modified by a push.
- The RAS holds ADDR_W-bit values only. No wrap of SP_COUNT ever occurs because of the overflow/underflow suppression above.
- FROM_IMMED is ignored for every op except JUMP and CALL.
- Reset asserted in the same cycle as any op: reset wins; the op is discarded.
- The RAS is implementable as a register array; no RAM macro is required.

Test Plan:
- Reset then INC x3 -> PC_COUNT 'h000, 'h001, 'h002, 'h003; SP_COUNT=0; STACK_EMPTY=1; STACK_ERR=0.
- PC='h3FF, INC -> PC='h000. JUMP with FROM_IMMED='h155 -> PC='h155.
- PC='h010, CALL 'h200 -> PC='h200, TOS='h011, SP=1. Then RET -> PC='h011, SP=0, STACK_EMPTY=1.
- Nesting: PC='h010, CALL 'h100; then from PC='h100, CALL 'h300; then INTR at PC='h300 -> PC='h3FF, SP=3, TOS='h300. Then RETI, RET, RET -> PC='h300, then 'h101, then 'h011.
- Fill with DEPTH=8 CALLs. Then a 9th CALL 'h050 -> PC, SP (8) and TOS unchanged; STACK_FULL=1; STACK_ERR=1. Subsequent HOLDs keep STACK_ERR=1. RST clears it and sets PC='h000, SP=0.
- RET at SP=0 -> PC unchanged, STACK_ERR=1. RST and CALL asserted in the same cycle -> PC=RESET_VEC, SP=0. PC_OP=111 -> no change.
